melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 49 ++++
 rtl/melody_rom.sv | 20 ++
 rtl/melody_sequencer.sv | 175 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared constants and types for the melody sequencer: tone periods, score entry
// layout and the sequencer state type.
package melody_pkg;

    localparam int PITCH_W = 5;
    localparam int DUR_W = 3;
    localparam int ENTRY_W = PITCH_W + DUR_W;
    localparam int IDX_W = 5;
    localparam int NUM_PITCHES = 21;

    localparam logic [PITCH_W-1:0] PITCH_REST = 5'd31;
    localparam logic [DUR_W-1:0] DUR_END = 3'd0;

    // PWM periods for the low, middle and high octaves (do..ti)
    localparam logic [31:0] PERIOD_L1 = 32'd191130;
    localparam logic [31:0] PERIOD_L2 = 32'd170241;
    localparam logic [31:0] PERIOD_L3 = 32'd151698;
    localparam logic [31:0] PERIOD_L4 = 32'd143183;
    localparam logic [31:0] PERIOD_L5 = 32'd127550;
    localparam logic [31:0] PERIOD_L6 = 32'd113635;
    localparam logic [31:0] PERIOD_L7 = 32'd101234;
    localparam logic [31:0] PERIOD_M1 = 32'd95546;
    localparam logic [31:0] PERIOD_M2 = 32'd85134;
    localparam logic [31:0] PERIOD_M3 = 32'd75837;
    localparam logic [31:0] PERIOD_M4 = 32'd71581;
    localparam logic [31:0] PERIOD_M5 = 32'd63775;
    localparam logic [31:0] PERIOD_M6 = 32'd56817;
    localparam logic [31:0] PERIOD_M7 = 32'd50617;
    localparam logic [31:0] PERIOD_H1 = 32'd47823;
    localparam logic [31:0] PERIOD_H2 = 32'd42563;
    localparam logic [31:0] PERIOD_H3 = 32'd37921;
    localparam logic [31:0] PERIOD_H4 = 32'd35793;
    localparam logic [31:0] PERIOD_H5 = 32'd31887;
    localparam logic [31:0] PERIOD_H6 = 32'd28408;
    localparam logic [31:0] PERIOD_H7 = 32'd25309;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP
    } state_t;

endpackage

// File: rtl/melody_rom.sv
// Score storage: combinational lookup of one 8-bit entry {pitch, dur} per address.
module melody_rom
    import melody_pkg::*;
(
    input  logic [IDX_W-1:0]   addr,
    output logic [ENTRY_W-1:0] entry
);

    // Every unused address reads as an END marker so a stray index stops playback
    always_comb begin
        entry = {5'd0, DUR_END};
        case (addr)
            5'd0: entry = {5'd7, 3'd2};
            5'd1: entry = {PITCH_REST, 3'd1};
            5'd2: entry = {5'd14, 3'd1};
            default: entry = {5'd0, DUR_END};
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Walks the score ROM, driving a PWM period and enable for each note, with a
// short silent gap after every entry; supports looping, stop and restart.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned SCORE_LEN   = 32
) (
    input  logic             Clk50M,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [31:0]      counter_arr,
    output logic             tone_en,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] note_idx
);

    localparam logic [31:0] BEAT_LEN = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_LEN - 1);

    state_t state;
    state_t state_next;

    entry_t cur_entry;
    logic [31:0] timer;
    logic [31:0] timer_next;
    logic [31:0] arr_next;
    logic [IDX_W-1:0] idx_next;
    logic tone_next;
    logic done_next;
    logic score_end;
    logic [31:0] play_len;
    logic is_rest;

    melody_rom u_rom (
        .addr  (note_idx),
        .entry (cur_entry)
    );

    function automatic logic [31:0] pitch_period(input logic [PITCH_W-1:0] pitch);
        logic [31:0] period;
        period = PERIOD_L1;
        case (pitch)
            5'd0:  period = PERIOD_L1;
            5'd1:  period = PERIOD_L2;
            5'd2:  period = PERIOD_L3;
            5'd3:  period = PERIOD_L4;
            5'd4:  period = PERIOD_L5;
            5'd5:  period = PERIOD_L6;
            5'd6:  period = PERIOD_L7;
            5'd7:  period = PERIOD_M1;
            5'd8:  period = PERIOD_M2;
            5'd9:  period = PERIOD_M3;
            5'd10: period = PERIOD_M4;
            5'd11: period = PERIOD_M5;
            5'd12: period = PERIOD_M6;
            5'd13: period = PERIOD_M7;
            5'd14: period = PERIOD_H1;
            5'd15: period = PERIOD_H2;
            5'd16: period = PERIOD_H3;
            5'd17: period = PERIOD_H4;
            5'd18: period = PERIOD_H5;
            5'd19: period = PERIOD_H6;
            5'd20: period = PERIOD_H7;
            default: period = PERIOD_L1;
        endcase
        return period;
    endfunction

    // Codes above H7 (including the dedicated REST code) are all silent
    assign is_rest = (cur_entry.pitch >= 5'(NUM_PITCHES));
    assign play_len = {29'd0, cur_entry.dur} * BEAT_LEN;
    assign busy = (state != IDLE);

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next = note_idx;
        arr_next = counter_arr;
        tone_next = tone_en;
        timer_next = timer;
        done_next = 1'b0;
        score_end = 1'b0;

        if (stop) begin
            state_next = IDLE;
            idx_next = '0;
            tone_next = 1'b0;
            timer_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = FETCH;
                        idx_next = '0;
                    end
                end
                FETCH: begin
                    if (cur_entry.dur == DUR_END) begin
                        score_end = 1'b1;
                    end else begin
                        state_next = PLAY;
                        timer_next = play_len - 32'd1;
                        if (!is_rest) begin
                            arr_next = pitch_period(cur_entry.pitch);
                            tone_next = 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (timer == '0) begin
                        state_next = GAP;
                        timer_next = GAP_LAST;
                        tone_next = 1'b0;
                    end else begin
                        timer_next = timer - 32'd1;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer_next = timer - 32'd1;
                    end else if (note_idx == LAST_IDX) begin
                        score_end = 1'b1;
                    end else begin
                        state_next = FETCH;
                        idx_next = note_idx + 5'd1;
                    end
                end
                default: state_next = IDLE;
            endcase

            // A full score with no END marker wraps the same way an END does
            if (score_end) begin
                idx_next = '0;
                timer_next = '0;
                tone_next = 1'b0;
                if (loop_en) begin
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                    done_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            note_idx <= '0;
            counter_arr <= PERIOD_L1;
            tone_en <= 1'b0;
            done <= 1'b0;
            timer <= '0;
        end else begin
            note_idx <= idx_next;
            counter_arr <= arr_next;
            tone_en <= tone_next;
            done <= done_next;
            timer <= timer_next;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench: a score-level playback model predicts every output cycle
// under directed and random start/stop/loop/reset activity.
module tb_melody_sequencer;

    localparam int BEAT = 10;
    localparam int GAPC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop_en = 1'b0;
    logic [31:0] counter_arr;
    logic tone_en;
    logic busy;
    logic done;
    logic [4:0] note_idx;

    melody_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .SCORE_LEN   (32)
    ) dut (
        .Clk50M      (clk),
        .Rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .counter_arr (counter_arr),
        .tone_en     (tone_en),
        .busy        (busy),
        .done        (done),
        .note_idx    (note_idx)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [31:0] arr;
        logic        tone;
        logic        bsy;
        logic        dn;
        logic [4:0]  idx;
    } exp_t;

    int errors = 0;
    int checks = 0;
    int cnt_m1 = 0;
    int cnt_h1 = 0;
    int cnt_rest = 0;
    int cnt_done = 0;
    int cnt_busy = 0;

    exp_t cur;
    exp_t q[$];
    bit active = 1'b0;
    bit loop_r = 1'b0;

    int periods[21] = '{191130, 170241, 151698, 143183, 127550, 113635, 101234,
                        95546, 85134, 75837, 71581, 63775, 56817, 50617,
                        47823, 42563, 37921, 35793, 31887, 28408, 25309};

    function automatic exp_t mk(input logic [31:0] a, input logic t, input logic b,
                                input logic d, input logic [4:0] i);
        exp_t e;
        e.arr = a;
        e.tone = t;
        e.bsy = b;
        e.dn = d;
        e.idx = i;
        return e;
    endfunction

    function automatic int score_at(input int i);
        int e;
        case (i)
            0: e = 7 * 8 + 2;
            1: e = 31 * 8 + 1;
            2: e = 14 * 8 + 1;
            default: e = 0;
        endcase
        return e;
    endfunction

    // One complete pass over the score, one record per clock cycle
    function automatic void expand_pass(input logic [31:0] arr_in);
        logic [31:0] arr;
        arr = arr_in;
        q.delete();
        for (int i = 0; i < 32; i++) begin
            int pitch;
            int dur;
            bit sounding;
            pitch = score_at(i) / 8;
            dur = score_at(i) % 8;
            q.push_back(mk(arr, 1'b0, 1'b1, 1'b0, 5'(i)));
            if (dur == 0) break;
            sounding = (pitch <= 20);
            if (sounding) arr = 32'(periods[pitch]);
            repeat (dur * BEAT) q.push_back(mk(arr, sounding, 1'b1, 1'b0, 5'(i)));
            repeat (GAPC) q.push_back(mk(arr, 1'b0, 1'b1, 1'b0, 5'(i)));
        end
    endfunction

    function automatic void model_advance(input bit s, input bit p, input bit l);
        if (p) begin
            cur = mk(cur.arr, 1'b0, 1'b0, 1'b0, 5'd0);
            q.delete();
            active = 1'b0;
        end else if (!active) begin
            if (s) begin
                expand_pass(cur.arr);
                cur = q.pop_front();
                active = 1'b1;
            end else begin
                cur = mk(cur.arr, 1'b0, 1'b0, 1'b0, 5'd0);
            end
        end else if (q.size() == 0) begin
            if (l) begin
                expand_pass(cur.arr);
                cur = q.pop_front();
            end else begin
                cur = mk(cur.arr, 1'b0, 1'b0, 1'b1, 5'd0);
                active = 1'b0;
            end
        end else begin
            cur = q.pop_front();
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic compare_model();
        checks++;
        if (counter_arr !== cur.arr || tone_en !== cur.tone || busy !== cur.bsy ||
            done !== cur.dn || note_idx !== cur.idx) begin
            errors++;
            $display("[TB] FAIL model_cycle t=%0t: got arr=%0d tone=%0b busy=%0b done=%0b idx=%0d, expected arr=%0d tone=%0b busy=%0b done=%0b idx=%0d",
                     $time, counter_arr, tone_en, busy, done, note_idx,
                     cur.arr, cur.tone, cur.bsy, cur.dn, cur.idx);
        end
        if (tone_en && counter_arr == 32'd95546) cnt_m1++;
        if (tone_en && counter_arr == 32'd47823) cnt_h1++;
        if (busy && !tone_en && note_idx == 5'd1 && counter_arr == 32'd95546) cnt_rest++;
        if (done) cnt_done++;
        if (busy) cnt_busy++;
    endtask

    task automatic clear_stats();
        cnt_m1 = 0;
        cnt_h1 = 0;
        cnt_rest = 0;
        cnt_done = 0;
        cnt_busy = 0;
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit l);
        @(negedge clk);
        compare_model();
        start = s;
        stop = p;
        loop_en = l;
        model_advance(s, p, l);
    endtask

    task automatic reset_checks(input string tag);
        checkOutput({tag, "_tone"}, int'(tone_en), 0);
        checkOutput({tag, "_arr"}, int'(counter_arr), 191130);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_idx"}, int'(note_idx), 0);
    endtask

    // Asserts reset between clock edges to observe its asynchronous effect
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        #1;
        reset_checks(tag);
        cur = mk(32'd191130, 1'b0, 1'b0, 1'b0, 5'd0);
        q.delete();
        active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #15;
        reset_checks("por");
        cur = mk(32'd191130, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full pass without looping
        clear_stats();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_m1_tone_cycles", cnt_m1, 20);
        checkOutput("t2_rest_cycles", cnt_rest, 13);
        checkOutput("t2_h1_tone_cycles", cnt_h1, 10);
        checkOutput("t3_done_pulses", cnt_done, 1);
        checkOutput("t3_busy_cycles", cnt_busy, 50);
        checkOutput("t3_idle_busy", int'(busy), 0);
        checkOutput("t3_idle_idx", int'(note_idx), 0);

        // Looping replay, then stop together with start
        clear_stats();
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (51) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_replay_idx", int'(note_idx), 0);
        checkOutput("t4_replay_busy", int'(busy), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_replay_tone", int'(tone_en), 1);
        checkOutput("t4_replay_arr", int'(counter_arr), 95546);
        checkOutput("t4_no_done", cnt_done, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_stop_busy", int'(busy), 0);
        checkOutput("t5_stop_tone", int'(tone_en), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_still_idle", int'(busy), 0);
        checkOutput("t5_no_done", cnt_done, 0);

        // Reset while a note sounds, then replay from the top
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_tone", int'(tone_en), 1);
        do_reset("t6_async");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_replay_tone", int'(tone_en), 1);
        checkOutput("t6_replay_arr", int'(counter_arr), 95546);
        checkOutput("t6_replay_idx", int'(note_idx), 0);

        // Random control activity checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            bit s;
            bit p;
            s = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 149) == 0) loop_r = ~loop_r;
            if ($urandom_range(0, 799) == 0) do_reset("rnd_reset");
            applyStimulus(s, p, loop_r);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
